keypad_scan_in: RTL and testbench

- Memory-mapped 4x4 matrix keypad input peripheral for the single-cycle CPU I/O space. It sits beside the switch input port.
- It drives keypad rows one at a time, samples the columns, and debounces the scanned key map.
- Each new single-key press is encoded as a 4-bit code and pushed into a small FIFO. The CPU pops the FIFO through the ioread path.
- It is the input counterpart of the display digit scanner: that block drives a scan out, this block reads a scan back in.

---
 rtl/keypad_scan_in.sv | 208 ++++++++++++++++++++
 tb/tb_keypad_scan_in.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_in.sv
// 4x4 matrix keypad scanner with frame debounce and a key-event FIFO read over the I/O bus.
// Optional auto-repeat of a held single key is built when KB_AUTOREPEAT_EN is defined.
module keypad_scan_in #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        kbcs,
    input  logic        kbread,
    input  logic [1:0]  kbaddr,
    output logic [15:0] kbrdata,
    output logic [3:0]  row_o,
    input  logic [3:0]  col_i,
    output logic        kb_irq
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    function automatic logic [3:0] key_code(input logic [15:0] map);
        key_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (map[i]) key_code = 4'(i);
        end
    endfunction

    logic [DIV_W-1:0] div;
    logic [1:0]       row;
    logic [3:0]       col_meta;
    logic [3:0]       col_sync;
    logic [15:0]      snapshot;
    logic [15:0]      prev_frame;
    logic [15:0]      stable;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_next;

    logic        row_end;
    logic        frame_end;
    logic [15:0] frame_snap;
    logic        stable_load;
    logic        map_change;
    logic        press_evt;
    logic        rep_push;
    logic [3:0]  rep_code;

    assign row_o      = ~(4'b0001 << row);
    assign row_end    = (div == DIV_W'(SCAN_DIV - 1));
    assign frame_end  = row_end && (row == 2'd3);
    // Row 3 columns are folded in here so the frame-end compare sees the whole frame.
    assign frame_snap = {~col_sync, snapshot[11:0]};

    always_comb begin
        deb_next = '0;
        if (frame_snap == prev_frame) begin
            deb_next = (deb_cnt == DEB_W'(DEBOUNCE_CNT)) ? deb_cnt : deb_cnt + DEB_W'(1);
        end
    end

    assign stable_load = frame_end && (deb_next == DEB_W'(DEBOUNCE_CNT));
    assign map_change  = stable_load && (frame_snap != stable);
    assign press_evt   = stable_load && (stable == 16'h0000) && $onehot(frame_snap);

    // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
    always_ff @(posedge clock) begin
        if (!reset) begin
            div        <= '0;
            row        <= 2'd0;
            col_meta   <= 4'hF;
            col_sync   <= 4'hF;
            snapshot   <= 16'h0000;
            prev_frame <= 16'h0000;
            stable     <= 16'h0000;
            deb_cnt    <= '0;
        end else begin
            col_meta <= col_i;
            col_sync <= col_meta;
            if (row_end) begin
                div <= '0;
                row <= row + 2'd1;
                snapshot[{row, 2'b00} +: 4] <= ~col_sync;
            end else begin
                div <= div + DIV_W'(1);
            end
            if (frame_end) begin
                prev_frame <= frame_snap;
                deb_cnt    <= deb_next;
            end
            if (stable_load) stable <= frame_snap;
        end
    end

`ifdef KB_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_next;
    logic             rep_armed;
    logic             rep_first;
    logic             rep_due;

    assign rep_next = rep_cnt + REP_W'(1);
    assign rep_due  = rep_first ? (rep_next == REP_W'(REPEAT_DELAY))
                                : (rep_next == REP_W'(REPEAT_RATE));
    assign rep_push = frame_end && rep_armed && !press_evt && !map_change && rep_due;
    assign rep_code = key_code(stable);

    always_ff @(posedge clock) begin
        if (!reset) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            rep_first <= 1'b0;
        end else if (frame_end) begin
            if (press_evt) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
                rep_first <= 1'b1;
            end else if (map_change) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (rep_armed) begin
                if (rep_due) begin
                    rep_cnt   <= '0;
                    rep_first <= 1'b0;
                end else begin
                    rep_cnt <= rep_next;
                end
            end
        end
    end
`else
    // Without auto-repeat the repeat timing has no effect; only press events are queued.
    assign rep_push = 1'b0 && (REPEAT_DELAY > 0) && (REPEAT_RATE > 0);
    assign rep_code = 4'h0;
`endif

    logic [3:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             nonempty;
    logic             full;
    logic             rd_sel;
    logic             data_rd;
    logic             stat_rd;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;
    logic [3:0]       push_code;

    assign nonempty  = (count != '0);
    assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign rd_sel    = kbcs && kbread;
    assign data_rd   = rd_sel && (kbaddr == 2'b00);
    assign stat_rd   = rd_sel && (kbaddr == 2'b10);
    assign push_req  = press_evt || rep_push;
    assign push      = push_req && !full;
    assign drop      = push_req && full;
    assign pop       = data_rd && nonempty;
    assign push_code = press_evt ? key_code(frame_snap) : rep_code;
    assign kb_irq    = nonempty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (stat_rd) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: the FIFO storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= push_code;
    end

    always_comb begin
        kbrdata = 16'h0000;
        if (rd_sel) begin
            case (kbaddr)
                2'b00:   kbrdata = {11'b0, nonempty, nonempty ? fifo_mem[rd_ptr] : 4'h0};
                2'b10:   kbrdata = {8'b0, 4'(count), 1'b0, overflow, full, nonempty};
                default: kbrdata = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_in.sv
// Directed bench for keypad_scan_in: a keypad matrix model drives the columns and a
// queue of expected key codes is checked against DATA/STATUS reads.
module tb_keypad_scan_in;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 2;
    localparam int FIFO_DEPTH   = 4;
    localparam int FRAME        = 4 * SCAN_DIV;

    logic        clock  = 1'b0;
    logic        reset  = 1'b0;
    logic        kbcs   = 1'b0;
    logic        kbread = 1'b0;
    logic [1:0]  kbaddr = 2'b00;
    logic [15:0] kbrdata;
    logic [3:0]  row_o;
    logic [3:0]  col_i;
    logic        kb_irq;

    logic [15:0] keys = 16'h0000;
    int          cyc;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [3:0]  exp_q[$];
    logic        ovf_m = 1'b0;

    keypad_scan_in #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .REPEAT_DELAY(50),
        .REPEAT_RATE (10)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .kbcs   (kbcs),
        .kbread (kbread),
        .kbaddr (kbaddr),
        .kbrdata(kbrdata),
        .row_o  (row_o),
        .col_i  (col_i),
        .kb_irq (kb_irq)
    );

    always #5 clock = ~clock;

    // Pressed key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_o[r] && keys[r*4+c]) col_i[c] = 1'b0;
            end
        end
    end

    always @(posedge clock) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input int code);
        if (exp_q.size() == FIFO_DEPTH) ovf_m = 1'b1;
        else                            exp_q.push_back(4'(code));
    endtask

    task automatic do_read(input logic [1:0] addr, output logic [15:0] data);
        @(negedge clock);
        kbcs   = 1'b1;
        kbread = 1'b1;
        kbaddr = addr;
        #1 data = kbrdata;
        @(posedge clock);
        #1;
        kbcs   = 1'b0;
        kbread = 1'b0;
        kbaddr = 2'b00;
    endtask

    task automatic read_data_check(input string tag);
        logic [15:0] d;
        logic [15:0] e;
        if (exp_q.size() > 0) e = {11'b0, 1'b1, exp_q.pop_front()};
        else                  e = 16'h0000;
        do_read(2'b00, d);
        check(tag, d, e);
    endtask

    task automatic read_status_check(input string tag);
        logic [15:0] d;
        logic [15:0] e;
        e = {8'b0, 4'(exp_q.size()), 1'b0, ovf_m,
             exp_q.size() == FIFO_DEPTH, exp_q.size() != 0};
        do_read(2'b10, d);
        check(tag, d, e);
        ovf_m = 1'b0;
    endtask

    task automatic hold_frames(input int n);
        repeat (n * FRAME) @(negedge clock);
    endtask

    task automatic press(input int code, input int frames, input bit expect_push);
        if (expect_push) model_push(code);
        keys = 16'(1) << code;
        hold_frames(frames);
        keys = 16'h0000;
        hold_frames(5);
    endtask

    initial begin
        int t0;

        // Reset state and row rotation
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_row", {12'b0, row_o}, 16'h000E);
        check("reset_rdata", kbrdata, 16'h0000);
        check("reset_irq", {15'b0, kb_irq}, 16'h0000);
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] e_row;
            e_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            check($sformatf("rotate_%0d", k), {12'b0, row_o}, {12'b0, e_row});
            @(negedge clock);
        end

        // Single press of row 2 / col 1
        press(9, 6, 1'b1);
        check("single_irq", {15'b0, kb_irq}, 16'h0001);
        read_status_check("single_status");
        read_data_check("single_data");
        read_status_check("single_status_after");

        // Bounce: key alternates every frame, never stable
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            hold_frames(1);
        end
        keys = 16'h0000;
        hold_frames(5);
        check("bounce_irq", {15'b0, kb_irq}, 16'h0000);
        read_status_check("bounce_status");

        // Ghost guard: two keys, then dropping to one key without passing through zero
        keys = 16'h1001;
        hold_frames(6);
        check("ghost_irq", {15'b0, kb_irq}, 16'h0000);
        keys = 16'h0001;
        hold_frames(6);
        check("ghost_to_single_irq", {15'b0, kb_irq}, 16'h0000);
        keys = 16'h0000;
        hold_frames(5);
        press(5, 6, 1'b1);
        read_data_check("after_ghost_data");

        // Overflow: five presses into a four-entry FIFO
        for (int c = 0; c < 5; c++) press(c, 6, 1'b1);
        read_status_check("ovf_status");
        for (int i = 0; i < 5; i++) read_data_check($sformatf("ovf_data_%0d", i));
        read_status_check("ovf_cleared");

        // Latency of a frame-aligned press
        while (cyc % FRAME != 0) @(negedge clock);
        t0 = cyc;
        model_push(6);
        keys = 16'h0040;
        for (int i = 0; i < 400 && !kb_irq; i++) @(negedge clock);
        check("press_latency", 16'(cyc - t0), 16'((DEBOUNCE_CNT + 1) * FRAME));
        hold_frames(2);
        keys = 16'h0000;
        hold_frames(5);
        press(7, 6, 1'b1);

        // DATA read on the push edge with two entries queued
        while (cyc % FRAME != 0) @(negedge clock);
        model_push(8);
        keys = 16'h0100;
        repeat ((DEBOUNCE_CNT + 1) * FRAME - 2) @(negedge clock);
        read_data_check("simul_data");
        hold_frames(2);
        keys = 16'h0000;
        hold_frames(5);
        read_status_check("simul_status");

        // Reset in mid-row with a DATA read pending
        while (cyc % SCAN_DIV != 2) @(negedge clock);
        reset  = 1'b0;
        kbcs   = 1'b1;
        kbread = 1'b1;
        kbaddr = 2'b00;
        @(posedge clock);
        #1;
        kbcs   = 1'b0;
        kbread = 1'b0;
        check("midreset_row", {12'b0, row_o}, 16'h000E);
        check("midreset_irq", {15'b0, kb_irq}, 16'h0000);
        exp_q.delete();
        ovf_m = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        read_status_check("midreset_status");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
